// File: rtl/ram_arbiter_2m_if.sv
// rtl/ram_arbiter_2m_if.sv - requester and RAM-side signal bundle for ram_arbiter_2m
interface ram_arbiter_2m_if;
    logic        m0_req;
    logic        m1_req;
    logic        m0_we;
    logic        m1_we;
    logic [7:0]  m0_addr;
    logic [7:0]  m1_addr;
    logic [31:0] m0_wdata;
    logic [31:0] m1_wdata;
    logic        m0_gnt;
    logic        m1_gnt;
    logic        m0_rvalid;
    logic        m1_rvalid;
    logic [31:0] m0_rdata;
    logic [31:0] m1_rdata;
    logic [7:0]  ram_addr;
    logic        ram_rw;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;
    logic        busy;

    modport slave (
        input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, ram_dout,
        output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
               ram_addr, ram_rw, ram_din, busy
    );

    modport master (
        output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, ram_dout,
        input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
               ram_addr, ram_rw, ram_din, busy
    );
endinterface

// File: rtl/ram_arbiter_2m.sv
// rtl/ram_arbiter_2m.sv - two-requester arbiter in front of a single-port synchronous RAM
module ram_arbiter_2m #(
    parameter bit RR_EN = 1'b1
) (
    input  logic               clk,
    input  logic               rst_n,
    ram_arbiter_2m_if.slave    arb_io
);

    typedef enum logic [1:0] {IDLE, ACCESS, RDATA} state_e;

    state_e      state_q;
    logic        last_grant_q;
    logic        busy_q;
    logic        m0_gnt_q;
    logic        m1_gnt_q;
    logic        m0_rvalid_q;
    logic        m1_rvalid_q;
    logic [31:0] m0_rdata_q;
    logic [31:0] m1_rdata_q;
    logic [7:0]  ram_addr_q;
    logic        ram_rw_q;
    logic [31:0] ram_din_q;

    logic        req_any;
    logic        win_d;
    logic        we_d;
    logic [7:0]  addr_d;
    logic [31:0] wdata_d;

    // win_d = 1 selects m1; contention goes to the requester not served last
    always_comb begin
        req_any = arb_io.m0_req | arb_io.m1_req;
        win_d   = arb_io.m1_req;
        if (arb_io.m0_req && arb_io.m1_req) begin
            win_d = RR_EN ? ~last_grant_q : 1'b0;
        end
        we_d    = win_d ? arb_io.m1_we    : arb_io.m0_we;
        addr_d  = win_d ? arb_io.m1_addr  : arb_io.m0_addr;
        wdata_d = win_d ? arb_io.m1_wdata : arb_io.m0_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            busy_q       <= 1'b0;
            m0_gnt_q     <= 1'b0;
            m1_gnt_q     <= 1'b0;
            m0_rvalid_q  <= 1'b0;
            m1_rvalid_q  <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
            ram_addr_q   <= '0;
            ram_rw_q     <= 1'b0;
            ram_din_q    <= '0;
        end else begin
            m0_gnt_q    <= 1'b0;
            m1_gnt_q    <= 1'b0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_any) begin
                        ram_addr_q   <= addr_d;
                        ram_rw_q     <= we_d;
                        ram_din_q    <= wdata_d;
                        last_grant_q <= win_d;
                        m0_gnt_q     <= ~win_d;
                        m1_gnt_q     <= win_d;
                        busy_q       <= 1'b1;
                        state_q      <= ACCESS;
                    end
                end
                ACCESS: begin
                    // the write commits on this edge, so the enable drops right after it
                    ram_rw_q <= 1'b0;
                    if (ram_rw_q) begin
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
                    end else begin
                        state_q <= RDATA;
                    end
                end
                RDATA: begin
                    if (last_grant_q) begin
                        m1_rdata_q  <= arb_io.ram_dout;
                        m1_rvalid_q <= 1'b1;
                    end else begin
                        m0_rdata_q  <= arb_io.ram_dout;
                        m0_rvalid_q <= 1'b1;
                    end
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign arb_io.m0_gnt    = m0_gnt_q;
    assign arb_io.m1_gnt    = m1_gnt_q;
    assign arb_io.m0_rvalid = m0_rvalid_q;
    assign arb_io.m1_rvalid = m1_rvalid_q;
    assign arb_io.m0_rdata  = m0_rdata_q;
    assign arb_io.m1_rdata  = m1_rdata_q;
    assign arb_io.ram_addr  = ram_addr_q;
    assign arb_io.ram_rw    = ram_rw_q;
    assign arb_io.ram_din   = ram_din_q;
    assign arb_io.busy      = busy_q;

endmodule

// File: tb/tb_ram_arbiter_2m.sv
// tb/tb_ram_arbiter_2m.sv - randomized and directed bench for ram_arbiter_2m against a latency model
module tb_ram_arbiter_2m;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_fp_n = 1'b0;
    always #5 clk = ~clk;

    ram_arbiter_2m_if bus();
    ram_arbiter_2m_if bus_fp();

    ram_arbiter_2m #(.RR_EN(1'b1)) dut    (.clk(clk), .rst_n(rst_n),    .arb_io(bus));
    ram_arbiter_2m #(.RR_EN(1'b0)) dut_fp (.clk(clk), .rst_n(rst_fp_n), .arb_io(bus_fp));

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit cmp_en = 1'b0;
    bit fp_done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h at cycle %0d", n, act, exp, cyc);
        end
    endfunction

    // RAM: synchronous read returning the pre-write contents
    logic [31:0] ram [256];
    always @(posedge clk) begin
        bus.ram_dout <= ram[bus.ram_addr];
        if (bus.ram_rw) ram[bus.ram_addr] = bus.ram_din;
    end

    // Reference: each grant books its visible effects into future-cycle slots
    logic [31:0] mem_m [256];
    bit          s_g0 [8], s_g1 [8], s_r0 [8], s_r1 [8], s_rw [8], s_busy [8];
    logic [31:0] s_d [8];
    bit          e_g0, e_g1, e_r0, e_r1, e_rw, e_busy;
    logic [31:0] e_rd0, e_rd1, e_din;
    logic [7:0]  e_addr;
    int          mcyc, next_s;
    bit          last_m;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 8; i++) begin
                s_g0[i] = 0; s_g1[i] = 0; s_r0[i] = 0; s_r1[i] = 0;
                s_rw[i] = 0; s_busy[i] = 0; s_d[i] = '0;
            end
            {e_g0, e_g1, e_r0, e_r1, e_rw, e_busy} = '0;
            e_rd0 = '0; e_rd1 = '0; e_din = '0; e_addr = '0;
            last_m = 1'b1; mcyc = 0; next_s = 0;
        end else begin
            if (mcyc >= next_s && (bus.m0_req || bus.m1_req)) begin
                bit w;
                bit we;
                logic [7:0] a;
                logic [31:0] d;
                w  = (bus.m0_req && bus.m1_req) ? !last_m : bus.m1_req;
                we = w ? bus.m1_we : bus.m0_we;
                a  = w ? bus.m1_addr : bus.m0_addr;
                d  = w ? bus.m1_wdata : bus.m0_wdata;
                last_m = w;
                s_g0[(mcyc + 1) % 8]   = !w;
                s_g1[(mcyc + 1) % 8]   = w;
                s_busy[(mcyc + 1) % 8] = 1'b1;
                s_rw[(mcyc + 1) % 8]   = we;
                e_addr = a;
                e_din  = d;
                if (we) begin
                    mem_m[a] = d;
                    next_s = mcyc + 2;
                end else begin
                    s_busy[(mcyc + 2) % 8] = 1'b1;
                    if (w) s_r1[(mcyc + 3) % 8] = 1'b1;
                    else   s_r0[(mcyc + 3) % 8] = 1'b1;
                    s_d[(mcyc + 3) % 8] = mem_m[a];
                    next_s = mcyc + 3;
                end
            end
            mcyc++;
            e_g0 = s_g0[mcyc % 8]; e_g1 = s_g1[mcyc % 8];
            e_r0 = s_r0[mcyc % 8]; e_r1 = s_r1[mcyc % 8];
            e_rw = s_rw[mcyc % 8]; e_busy = s_busy[mcyc % 8];
            if (e_r0) e_rd0 = s_d[mcyc % 8];
            if (e_r1) e_rd1 = s_d[mcyc % 8];
            s_g0[mcyc % 8] = 0; s_g1[mcyc % 8] = 0; s_r0[mcyc % 8] = 0;
            s_r1[mcyc % 8] = 0; s_rw[mcyc % 8] = 0; s_busy[mcyc % 8] = 0;
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m0_gnt",    32'(bus.m0_gnt),    32'(e_g0));
            chk("m1_gnt",    32'(bus.m1_gnt),    32'(e_g1));
            chk("m0_rvalid", 32'(bus.m0_rvalid), 32'(e_r0));
            chk("m1_rvalid", 32'(bus.m1_rvalid), 32'(e_r1));
            chk("m0_rdata",  bus.m0_rdata,       e_rd0);
            chk("m1_rdata",  bus.m1_rdata,       e_rd1);
            chk("ram_addr",  32'(bus.ram_addr),  32'(e_addr));
            chk("ram_rw",    32'(bus.ram_rw),    32'(e_rw));
            chk("ram_din",   bus.ram_din,        e_din);
            chk("busy",      32'(bus.busy),      32'(e_busy));
        end
    end

    int glog_m [$];
    int glog_c [$];

    task automatic set_req(input int m, input bit r);
        if (m == 0) bus.m0_req = r;
        else        bus.m1_req = r;
    endtask

    task automatic issue(input int m, input bit we, input logic [7:0] a, input logic [31:0] d,
                         output logic [31:0] rd, output int glat, output int rlat);
        int c0;
        bit got;
        c0 = cyc; glat = -1; rlat = -1; rd = '0; got = 1'b0;
        if (m == 0) begin bus.m0_we = we; bus.m0_addr = a; bus.m0_wdata = d; end
        else        begin bus.m1_we = we; bus.m1_addr = a; bus.m1_wdata = d; end
        set_req(m, 1'b1);
        for (int k = 0; k < 60 && !got; k++) begin
            @(negedge clk);
            if ((m == 0) ? bus.m0_gnt : bus.m1_gnt) got = 1'b1;
        end
        chk("gnt_seen", 32'(got), 32'd1);
        if (got) begin
            glat = cyc - c0;
            glog_m.push_back(m);
            glog_c.push_back(cyc);
            @(posedge clk); #1;
            set_req(m, 1'b0);
            if (!we) begin
                got = 1'b0;
                for (int k = 0; k < 6 && !got; k++) begin
                    @(negedge clk);
                    if ((m == 0) ? bus.m0_rvalid : bus.m1_rvalid) begin
                        got = 1'b1;
                        rlat = cyc - c0;
                        rd = (m == 0) ? bus.m0_rdata : bus.m1_rdata;
                    end
                end
                chk("rvalid_seen", 32'(got), 32'd1);
            end
        end else begin
            set_req(m, 1'b0);
        end
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic rand_thread(input int m, input int n);
        logic [7:0] edges [8];
        logic [31:0] rd;
        int g, r;
        edges = '{8'h00, 8'h3F, 8'h40, 8'h7F, 8'h80, 8'hBF, 8'hC0, 8'hFF};
        for (int i = 0; i < n; i++) begin
            int gap;
            logic [7:0] a;
            gap = $urandom_range(0, 2);
            a = ($urandom_range(0, 1) == 1) ? edges[$urandom_range(0, 7)] : 8'($urandom);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
            issue(m, 1'($urandom), a, $urandom, rd, g, r);
        end
    endtask

    // Fixed-priority instance: both requesters hold a read request forever
    initial begin
        int c0, n0, n1;
        bus_fp.m0_req = 1'b1; bus_fp.m1_req = 1'b1;
        bus_fp.m0_we = 1'b0;  bus_fp.m1_we = 1'b0;
        bus_fp.m0_addr = 8'h10; bus_fp.m1_addr = 8'h20;
        bus_fp.m0_wdata = '0; bus_fp.m1_wdata = '0;
        bus_fp.ram_dout = '0;
        n0 = 0; n1 = 0;
        repeat (3) @(posedge clk);
        #1 rst_fp_n = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            chk("s3_m0_gnt", 32'(bus_fp.m0_gnt), 32'(((cyc - c0) % 3) == 1));
            chk("s3_m1_gnt", 32'(bus_fp.m1_gnt), 32'd0);
            n0 += int'(bus_fp.m0_gnt);
            n1 += int'(bus_fp.m1_gnt);
        end
        chk("s3_m0_count", 32'(n0), 32'd10);
        chk("s3_m1_count", 32'(n1), 32'd0);
        fp_done = 1'b1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd, rd_a, rd_b;
        int g, r, g_b, r_b, nrv;
        bus.m0_req = 0; bus.m1_req = 0; bus.m0_we = 0; bus.m1_we = 0;
        bus.m0_addr = '0; bus.m1_addr = '0; bus.m0_wdata = '0; bus.m1_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            logic [31:0] v;
            v = $urandom;
            ram[i] = v;
            mem_m[i] = v;
        end
        @(posedge clk);
        #1 cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // write then read back from m0
        issue(0, 1'b1, 8'h05, 32'hDEADBEEF, rd, g, r);
        chk("s1_wr_glat", 32'(g), 32'd1);
        issue(0, 1'b0, 8'h05, '0, rd, g, r);
        chk("s1_rd_glat", 32'(g), 32'd1);
        chk("s1_rd_rlat", 32'(r), 32'd3);
        chk("s1_rdata", rd, 32'hDEADBEEF);
        chk("s1_m1_rdata", bus.m1_rdata, 32'd0);

        // boundary writes, then cross-requester readback
        @(posedge clk); #1;
        issue(0, 1'b1, 8'h3F, 32'hA5A5A5A5, rd, g, r);
        issue(0, 1'b1, 8'h40, 32'h5A5A5A5A, rd, g, r);
        issue(0, 1'b1, 8'hFF, 32'h000000FF, rd, g, r);
        issue(0, 1'b1, 8'h00, 32'hFFFFFFFF, rd, g, r);
        issue(1, 1'b0, 8'h3F, '0, rd, g, r); chk("s4_3f", rd, 32'hA5A5A5A5);
        issue(1, 1'b0, 8'h40, '0, rd, g, r); chk("s4_40", rd, 32'h5A5A5A5A);
        issue(1, 1'b0, 8'hFF, '0, rd, g, r); chk("s4_ff", rd, 32'h000000FF);
        issue(1, 1'b0, 8'h00, '0, rd, g, r); chk("s4_00", rd, 32'hFFFFFFFF);

        // round-robin contention straight out of reset
        ram[8'h10] = 32'h11111111; mem_m[8'h10] = 32'h11111111;
        ram[8'h20] = 32'h22222222; mem_m[8'h20] = 32'h22222222;
        do_reset();
        glog_m.delete(); glog_c.delete();
        fork
            begin
                logic [31:0] v;
                int ga, ra;
                for (int i = 0; i < 4; i++) begin
                    issue(0, 1'b0, 8'h10, '0, v, ga, ra);
                    chk("s2_m0_rdata", v, 32'h11111111);
                end
            end
            begin
                logic [31:0] v;
                int ga, ra;
                for (int i = 0; i < 4; i++) begin
                    issue(1, 1'b0, 8'h20, '0, v, ga, ra);
                    chk("s2_m1_rdata", v, 32'h22222222);
                end
            end
        join
        chk("s2_ngrants", 32'(glog_m.size()), 32'd8);
        if (glog_m.size() >= 4) begin
            for (int i = 0; i < 4; i++) begin
                chk("s2_order", 32'(glog_m[i]), 32'(i % 2));
                if (i > 0) chk("s2_spacing", 32'(glog_c[i] - glog_c[i-1]), 32'd3);
            end
        end

        // m1 request raised during m0's RDATA cycle
        @(posedge clk); #1;
        fork
            begin
                issue(0, 1'b0, 8'h10, '0, rd_a, g, r);
                chk("s5_m0_rlat", 32'(r), 32'd3);
            end
            begin
                repeat (2) @(posedge clk);
                #1;
                issue(1, 1'b0, 8'h20, '0, rd_b, g_b, r_b);
                chk("s5_m1_glat", 32'(g_b), 32'd2);
            end
        join

        // reset in the RDATA cycle of an m0 read
        @(posedge clk); #1;
        bus.m0_we = 1'b0; bus.m0_addr = 8'h20; bus.m0_req = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("s6_gnt", 32'(bus.m0_gnt), 32'd1);
        @(posedge clk); #1;
        bus.m0_req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("s6_busy", 32'(bus.busy), 32'd0);
        chk("s6_m0_rdata", bus.m0_rdata, 32'd0);
        chk("s6_ram_addr", 32'(bus.ram_addr), 32'd0);
        chk("s6_m0_gnt", 32'(bus.m0_gnt), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        nrv = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            nrv += int'(bus.m0_rvalid);
        end
        chk("s6_no_rvalid", 32'(nrv), 32'd0);
        @(posedge clk); #1;
        issue(1, 1'b0, 8'h10, '0, rd, g, r);
        chk("s6_m1_glat", 32'(g), 32'd1);
        chk("s6_m1_rdata", rd, 32'h11111111);

        // random traffic from both requesters
        @(posedge clk); #1;
        fork
            rand_thread(0, 40);
            rand_thread(1, 40);
        join
        repeat (5) @(posedge clk);
        chk("s3_done", 32'(fp_done), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
